light_sequence_monitor: RTL and testbench



---
 rtl/traffic_pkg.sv | 61 ++++++
 rtl/dwell_timer.sv | 35 +++
 rtl/light_sequence_monitor.sv | 183 ++++++++++++++++++
 tb/tb_light_sequence_monitor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and helpers for the traffic-light sequencer and its monitor.
package traffic_pkg;

  typedef enum logic [1:0] {
    PH_OFF   = 2'd0,
    PH_RED   = 2'd1,
    PH_GREEN = 2'd2,
    PH_AMBER = 2'd3
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE  = 3'd0,
    FC_MULTI = 3'd1,
    FC_ORDER = 3'd2,
    FC_SHORT = 3'd3,
    FC_LONG  = 3'd4,
    FC_GAP   = 3'd5
  } fault_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RED,
    ST_GREEN,
    ST_AMBER,
    ST_GAP,
    ST_FAULT
  } mon_state_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_AMBER;
      PH_AMBER: return PH_RED;
      default:  return PH_OFF;
    endcase
  endfunction

  function automatic phase_e state_phase(input mon_state_e s);
    case (s)
      ST_RED:   return PH_RED;
      ST_GREEN: return PH_GREEN;
      ST_AMBER: return PH_AMBER;
      default:  return PH_OFF;
    endcase
  endfunction

  function automatic mon_state_e phase_state(input phase_e p);
    case (p)
      PH_RED:   return ST_RED;
      PH_GREEN: return ST_GREEN;
      PH_AMBER: return ST_AMBER;
      default:  return ST_INIT;
    endcase
  endfunction

  // Short-dwell limit never drops below one cycle, even when TOL >= TICS.
  function automatic int unsigned lo_limit(input int unsigned tics, input int unsigned tol);
    return (tics > tol) ? tics - tol : 1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating lamp-on counter with low/high limit compares.
module dwell_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] lo_lim,
  input  logic [CNT_W-1:0] hi_lim,
  output logic [CNT_W-1:0] count,
  output logic             too_long,
  output logic             too_short
);

  logic [CNT_W-1:0] count_q, count_d, count_inc;

  always_comb begin
    count_inc = (&count_q) ? count_q : count_q + CNT_W'(1);
    count_d   = count_q;
    if (clr)     count_d = CNT_W'(1);
    else if (en) count_d = count_inc;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  // too_long looks at the value this sample produces, so the fault lands immediately.
  assign too_long  = en && (count_inc > hi_lim);
  assign too_short = count_q < lo_lim;
  assign count     = count_q;

endmodule

// File: rtl/light_sequence_monitor.sv
// Checks lamp order red->green->amber->red and per-lamp dwell; latches the first fault.
//   state    | meaning
//   ST_INIT  | waiting for a clean red to start monitoring
//   ST_RED   | red on, timing its dwell
//   ST_GREEN | green on, timing its dwell
//   ST_AMBER | amber on, timing its dwell
//   ST_GAP   | all lamps off between phases, expecting exp_q
//   ST_FAULT | first fault latched, waiting for fault_clr
module light_sequence_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned RED_TICS   = 350,
  parameter int unsigned GREEN_TICS = 200,
  parameter int unsigned AMBER_TICS = 30,
  parameter int unsigned TOL        = 0,
  parameter int unsigned GAP_MAX    = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             red,
  input  logic             green,
  input  logic             amber,
  input  logic             fault_clr,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             dwell_valid,
  output logic [CNT_W-1:0] cycle_count,
  output logic             fault,
  output logic [2:0]       fault_code
);

  localparam logic [CNT_W-1:0] RED_LO   = CNT_W'(lo_limit(RED_TICS, TOL));
  localparam logic [CNT_W-1:0] GREEN_LO = CNT_W'(lo_limit(GREEN_TICS, TOL));
  localparam logic [CNT_W-1:0] AMBER_LO = CNT_W'(lo_limit(AMBER_TICS, TOL));
  localparam logic [CNT_W-1:0] RED_HI   = CNT_W'(RED_TICS + TOL);
  localparam logic [CNT_W-1:0] GREEN_HI = CNT_W'(GREEN_TICS + TOL);
  localparam logic [CNT_W-1:0] AMBER_HI = CNT_W'(AMBER_TICS + TOL);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_MAX);

  mon_state_e       state_q, state_d;
  phase_e           exp_q, exp_d, phase_q, phase_d;
  phase_e           cur, nxt, lamp, tgt;
  fault_e           code_q, code_d, fc;
  logic [CNT_W-1:0] gap_q, gap_d, cycle_q, cycle_d, dwell_q, dwell_d;
  logic [CNT_W-1:0] lo_sel, hi_sel, tmr_count;
  logic             dv_q, dv_d, fault_q, fault_d;
  logic             tmr_clr, tmr_en, too_long, too_short, multi, go;

  dwell_timer #(.CNT_W(CNT_W)) u_timer (
    .clock     (clock),
    .reset_n   (reset_n),
    .clr       (tmr_clr),
    .en        (tmr_en),
    .lo_lim    (lo_sel),
    .hi_lim    (hi_sel),
    .count     (tmr_count),
    .too_long  (too_long),
    .too_short (too_short)
  );

  always_comb begin
    multi = (red & green) | (red & amber) | (green & amber);
    lamp  = red ? PH_RED : green ? PH_GREEN : amber ? PH_AMBER : PH_OFF;
    cur   = state_phase(state_q);
    nxt   = next_phase(cur);
    case (cur)
      PH_RED:   begin lo_sel = RED_LO;   hi_sel = RED_HI;   end
      PH_GREEN: begin lo_sel = GREEN_LO; hi_sel = GREEN_HI; end
      default:  begin lo_sel = AMBER_LO; hi_sel = AMBER_HI; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    gap_d   = gap_q;
    cycle_d = cycle_q;
    dwell_d = dwell_q;
    dv_d    = 1'b0;
    fault_d = fault_q;
    code_d  = code_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    fc      = FC_NONE;
    go      = 1'b0;
    tgt     = PH_OFF;
    case (state_q)
      ST_INIT: begin
        if (red && !green && !amber) begin
          state_d = ST_RED;
          tmr_clr = 1'b1;
        end
      end
      ST_RED, ST_GREEN, ST_AMBER: begin
        if (multi) fc = FC_MULTI;
        else if (lamp == cur) begin
          tmr_en = 1'b1;
          if (too_long) fc = FC_LONG;
        end
        else if (lamp != PH_OFF && lamp != nxt) fc = FC_ORDER;
        else if (too_short) fc = FC_SHORT;
        else if (lamp == PH_OFF && GAP_MAX == 0) fc = FC_GAP;
        else begin
          dwell_d = tmr_count;
          dv_d    = 1'b1;
          if (lamp == PH_OFF) begin
            state_d = ST_GAP;
            exp_d   = nxt;
            gap_d   = CNT_W'(1);
          end else begin
            go  = 1'b1;
            tgt = nxt;
          end
        end
      end
      ST_GAP: begin
        if (multi) fc = FC_MULTI;
        else if (lamp == exp_q) begin
          go  = 1'b1;
          tgt = exp_q;
        end
        else if (lamp != PH_OFF) fc = FC_ORDER;
        else begin
          gap_d = gap_q + CNT_W'(1);
          if (gap_q >= GAP_LIM) fc = FC_GAP;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_INIT;
          fault_d = 1'b0;
          code_d  = FC_NONE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    if (go) begin
      state_d = phase_state(tgt);
      tmr_clr = 1'b1;
      if (tgt == PH_RED) cycle_d = cycle_q + CNT_W'(1);
    end
    if (fc != FC_NONE) begin
      state_d = ST_FAULT;
      fault_d = 1'b1;
      code_d  = fc;
    end
    phase_d = state_phase(state_d);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      exp_q   <= PH_OFF;
      phase_q <= PH_OFF;
      gap_q   <= '0;
      cycle_q <= '0;
      dwell_q <= '0;
      dv_q    <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
      cycle_q <= cycle_d;
      dwell_q <= dwell_d;
      dv_q    <= dv_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  assign phase       = phase_q;
  assign dwell       = dwell_q;
  assign dwell_valid = dv_q;
  assign cycle_count = cycle_q;
  assign fault       = fault_q;
  assign fault_code  = code_q;

endmodule

// File: tb/tb_light_sequence_monitor.sv
// Directed bench for light_sequence_monitor with a per-cycle behavioural model.
module tb_light_sequence_monitor;

  localparam int TOL     = 0;
  localparam int GAP_MAX = 1;
  localparam int CMAX    = 65535;
  localparam int TICS [3] = '{350, 200, 30};

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        red = 1'b0, green = 1'b0, amber = 1'b0, fault_clr = 1'b0;
  logic [1:0]  phase;
  logic [15:0] dwell, cycle_count;
  logic        dwell_valid, fault;
  logic [2:0]  fault_code;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  light_sequence_monitor #(
    .RED_TICS(350), .GREEN_TICS(200), .AMBER_TICS(30),
    .TOL(TOL), .GAP_MAX(GAP_MAX), .CNT_W(16)
  ) dut (
    .clock(clock), .reset_n(reset_n), .red(red), .green(green), .amber(amber),
    .fault_clr(fault_clr), .phase(phase), .dwell(dwell), .dwell_valid(dwell_valid),
    .cycle_count(cycle_count), .fault(fault), .fault_code(fault_code)
  );

  always #5 clock = ~clock;

  function automatic int lo_of(input int i);
    return (TICS[i] > TOL) ? TICS[i] - TOL : 1;
  endfunction

  // Model: lamp index 0=red,1=green,2=amber; m_cur is the lit lamp, or the awaited one while dark.
  int m_mode = 0;  // 0 waiting for red, 1 lamp on, 2 dark between lamps, 3 faulted
  int m_cur = 0, m_run = 0, m_off = 0;
  logic [1:0]  e_phase;
  logic [15:0] e_dwell, e_cycle;
  logic        e_dv, e_fault;
  logic [2:0]  e_code;

  always @(posedge clock) begin
    int lit, lamp, nxt, code;
    lit  = int'(red) + int'(green) + int'(amber);
    lamp = (lit == 0) ? -1 : red ? 0 : green ? 1 : 2;
    nxt  = (m_cur + 1) % 3;
    code = 0;
    e_dv = 1'b0;
    if (!reset_n) begin
      m_mode = 0; e_dwell = '0; e_cycle = '0; e_fault = 1'b0; e_code = '0;
    end else begin
      case (m_mode)
        0: if (lit == 1 && red) begin m_mode = 1; m_cur = 0; m_run = 1; end
        1: begin
          if (lit > 1) code = 1;
          else if (lamp == m_cur) begin
            if (m_run < CMAX) m_run++;
            if (m_run > TICS[m_cur] + TOL) code = 4;
          end
          else if (lamp >= 0 && lamp != nxt) code = 2;
          else if (m_run < lo_of(m_cur)) code = 3;
          else if (lamp < 0 && GAP_MAX == 0) code = 5;
          else begin
            e_dwell = 16'(m_run);
            e_dv    = 1'b1;
            m_cur   = nxt;
            if (lamp < 0) begin m_mode = 2; m_off = 1; end
            else begin m_run = 1; if (nxt == 0) e_cycle++; end
          end
        end
        2: begin
          if (lit > 1) code = 1;
          else if (lamp == m_cur) begin m_mode = 1; m_run = 1; if (m_cur == 0) e_cycle++; end
          else if (lamp >= 0) code = 2;
          else begin m_off++; if (m_off > GAP_MAX) code = 5; end
        end
        default: if (fault_clr) begin m_mode = 0; e_fault = 1'b0; e_code = '0; end
      endcase
      if (code != 0) begin m_mode = 3; e_fault = 1'b1; e_code = 3'(code); end
    end
    e_phase = (m_mode == 1) ? 2'(m_cur + 1) : 2'd0;
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp("phase", 32'(phase), 32'(e_phase));
      cmp("dwell", 32'(dwell), 32'(e_dwell));
      cmp("dwell_valid", 32'(dwell_valid), 32'(e_dv));
      cmp("cycle_count", 32'(cycle_count), 32'(e_cycle));
      cmp("fault", 32'(fault), 32'(e_fault));
      cmp("fault_code", 32'(fault_code), 32'(e_code));
    end
  end

  // Each call applies n samples; it returns at the negedge where the last sample's result is visible.
  task automatic drive(input logic r, g, a, c, rn, input int n);
    for (int i = 0; i < n; i++) begin
      red = r; green = g; amber = a; fault_clr = c; reset_n = rn;
      @(negedge clock);
    end
  endtask

  task automatic lamps(input logic r, g, a, input int n);
    drive(r, g, a, 1'b0, 1'b1, n);
  endtask

  task automatic clr_pulse();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1);
  endtask

  initial begin
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3);
    chk_en = 1'b1;
    cmp("lit_reset_fault", 32'(fault), 0);
    cmp("lit_reset_phase", 32'(phase), 0);
    cmp("lit_reset_cycle", 32'(cycle_count), 0);

    lamps(0, 0, 0, 5);
    lamps(0, 1, 0, 3);
    cmp("lit_init_ignores_green", 32'(phase), 0);

    // three clean cycles
    lamps(1, 0, 0, 1);
    cmp("lit_red_entry", 32'(phase), 1);
    for (int k = 0; k < 3; k++) begin
      lamps(1, 0, 0, 349);
      lamps(0, 1, 0, 1);
      cmp("lit_red_dwell", 32'(dwell), 350);
      cmp("lit_red_dv", 32'(dwell_valid), 1);
      lamps(0, 1, 0, 199);
      lamps(0, 0, 1, 1);
      cmp("lit_green_dwell", 32'(dwell), 200);
      lamps(0, 0, 1, 29);
      lamps(1, 0, 0, 1);
      cmp("lit_amber_dwell", 32'(dwell), 30);
      cmp("lit_cycle", 32'(cycle_count), 32'(k + 1));
    end
    cmp("lit_clean_fault", 32'(fault), 0);

    // gap of 1 tolerated, fault_clr outside FAULT ignored, gap of 2 faults
    lamps(1, 0, 0, 349);
    lamps(0, 0, 0, 1);
    cmp("lit_gap1_dwell", 32'(dwell), 350);
    lamps(0, 1, 0, 100);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    lamps(0, 1, 0, 99);
    cmp("lit_gap1_nofault", 32'(fault), 0);
    lamps(0, 0, 0, 1);
    cmp("lit_gap2_first", 32'(fault), 0);
    lamps(0, 0, 0, 1);
    cmp("lit_gap2_fault", 32'(fault), 1);
    cmp("lit_gap2_code", 32'(fault_code), 5);
    lamps(0, 0, 0, 3);
    clr_pulse();
    cmp("lit_clr_fault", 32'(fault), 0);
    cmp("lit_clr_code", 32'(fault_code), 0);
    cmp("lit_clr_cycle", 32'(cycle_count), 3);

    // short red
    lamps(1, 0, 0, 349);
    cmp("lit_short_pre", 32'(fault), 0);
    lamps(0, 1, 0, 1);
    cmp("lit_short_code", 32'(fault_code), 3);
    clr_pulse();

    // long green
    lamps(1, 0, 0, 350);
    lamps(0, 1, 0, 200);
    cmp("lit_long_pre", 32'(fault), 0);
    lamps(0, 1, 0, 1);
    cmp("lit_long_fault", 32'(fault), 1);
    cmp("lit_long_code", 32'(fault_code), 4);
    clr_pulse();

    // two lamps together
    lamps(1, 0, 0, 10);
    lamps(1, 1, 0, 1);
    cmp("lit_multi_code", 32'(fault_code), 1);
    clr_pulse();

    // red straight to amber
    lamps(1, 0, 0, 350);
    lamps(0, 0, 1, 1);
    cmp("lit_order_code", 32'(fault_code), 2);
    clr_pulse();
    cmp("lit_order_cycle", 32'(cycle_count), 3);

    // reset mid-red, green-first start ignored, then a clean cycle
    lamps(1, 0, 0, 99);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1);
    cmp("lit_rst_phase", 32'(phase), 0);
    cmp("lit_rst_cycle", 32'(cycle_count), 0);
    cmp("lit_rst_dwell", 32'(dwell), 0);
    lamps(0, 1, 0, 50);
    lamps(0, 0, 0, 3);
    cmp("lit_rst_green_ignored", 32'(phase), 0);
    lamps(1, 0, 0, 350);
    lamps(0, 1, 0, 200);
    lamps(0, 0, 1, 30);
    lamps(1, 0, 0, 1);
    cmp("lit_rst_resume_cycle", 32'(cycle_count), 1);
    cmp("lit_rst_resume_fault", 32'(fault), 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
